// File: rtl/truth_table_scanner_if.sv
// Stimulus/capture bundle between the truth-table scanner and the harness that drives f_in.
// The harness side (master) drives start and f_in; the scanner side (slave) drives everything else.
interface truth_table_scanner_if #(
  parameter int unsigned N_IN = 4
) ();
  localparam int unsigned NVEC = 2 ** N_IN;

  logic                start;
  logic                f_in;
  logic [N_IN-1:0]     vec;
  logic                busy;
  logic                done;
  logic [NVEC-1:0]     table_out;
  logic [N_IN:0]       mismatch_cnt;
  logic [N_IN-1:0]     first_fail;
  logic                fail_valid;
  logic                pass;

  modport master (
    output start, f_in,
    input  vec, busy, done, table_out, mismatch_cnt, first_fail, fail_valid, pass
  );

  modport slave (
    input  start, f_in,
    output vec, busy, done, table_out, mismatch_cnt, first_fail, fail_valid, pass
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of an N_IN-input Boolean block, samples f_in after SETTLE cycles,
// builds the truth table and scores it against EXPECTED.
module truth_table_scanner #(
  parameter int unsigned        N_IN     = 4,
  parameter int unsigned        SETTLE   = 1,
  parameter logic [2**N_IN-1:0] EXPECTED = 16'hF031
) (
  input  logic                   clk,
  input  logic                   rst,
  truth_table_scanner_if.slave   bus
);

  localparam int unsigned NVEC = 2 ** N_IN;
  localparam int unsigned CW   = 4;
  localparam int unsigned MW   = N_IN + 1;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NVEC-1:0]   table_q, table_d;
  logic [MW-1:0]     mis_q, mis_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              fv_q, fv_d;
  logic              pass_q, pass_d;

  logic              sample_c;
  logic              last_c;
  logic              miss_c;

  assign sample_c = (state_q == SCAN) && (cnt_q == CW'(1));
  assign last_c   = (vec_q == LAST_VEC);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (sample_c && last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered datapath and outputs
  always_comb begin
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    mis_d   = mis_q;
    ff_d    = ff_q;
    fv_d    = fv_q;
    pass_d  = pass_q;
    miss_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          table_d = '0;
          mis_d   = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
          busy_d  = 1'b1;
          cnt_d   = CW'(SETTLE);
        end
      end
      SCAN: begin
        cnt_d = cnt_q - CW'(1);
        if (sample_c) begin
          table_d[vec_q] = bus.f_in;
          miss_c = (bus.f_in != EXPECTED[vec_q]);
          if (miss_c) mis_d = mis_q + MW'(1);
          if (miss_c && !fv_q) begin
            ff_d = vec_q;
            fv_d = 1'b1;
          end
          if (last_c) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (mis_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
            cnt_d = CW'(SETTLE);
          end
        end
      end
      DONE: vec_d = '0;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      mis_q   <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      mis_q   <= mis_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.vec          = vec_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.table_out    = table_q;
  assign bus.mismatch_cnt = mis_q;
  assign bus.first_fail   = ff_q;
  assign bus.fail_valid   = fv_q;
  assign bus.pass         = pass_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: a SETTLE=1 and a SETTLE=3 instance driven by
// selectable f_in models (correct, stuck-0, vector-9 fault, inverted, 2-cycle delayed).
module tb_truth_table_scanner;

  localparam logic [15:0] EXP = 16'hF031;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;
  int   checks = 0;
  int   failures = 0;

  truth_table_scanner_if #(.N_IN(4)) if1 ();
  truth_table_scanner_if #(.N_IN(4)) if3 ();

  truth_table_scanner #(.N_IN(4), .SETTLE(1), .EXPECTED(EXP)) dut_s1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );
  truth_table_scanner #(.N_IN(4), .SETTLE(3), .EXPECTED(EXP)) dut_s3 (
    .clk(clk), .rst(rst), .bus(if3.slave)
  );

  always #5 clk = ~clk;

  // Two-cycle delayed copies of each vec for the slow-block model
  logic [3:0] d1_a, d1_b, d3_a, d3_b;
  always @(posedge clk) begin
    d1_a <= if1.vec; d1_b <= d1_a;
    d3_a <= if3.vec; d3_b <= d3_a;
  end

  function automatic logic model(input int m, input logic [3:0] v, input logic [3:0] vd);
    logic [15:0] e;
    e = EXP;
    case (m)
      1:       return 1'b0;
      2:       return (v == 4'd9) ? 1'b1 : e[v];
      3:       return ~e[v];
      4:       return e[vd];
      default: return e[v];
    endcase
  endfunction

  always_comb if1.f_in = model(mode, if1.vec, d1_b);
  always_comb if3.f_in = model(mode, if3.vec, d3_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start on the selected instance; lat = cycles from busy rising to done
  task automatic run_scan(input int sel, output int lat);
    logic bsy, dn;
    @(posedge clk); #1;
    if (sel == 3) if3.start = 1'b1; else if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0; if3.start = 1'b0;
    bsy = (sel == 3) ? if3.busy : if1.busy;
    check("busy_rise", 32'(bsy), 32'd1);
    lat = 0;
    dn = 1'b0;
    while (!dn && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      dn = (sel == 3) ? if3.done : if1.done;
    end
  endtask

  int lat;
  int dones;

  initial begin
    if1.start = 1'b0;
    if3.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vec",   32'(if1.vec), 32'd0);
    check("rst_busy",  32'(if1.busy), 32'd0);
    check("rst_done",  32'(if1.done), 32'd0);
    check("rst_table", 32'(if1.table_out), 32'd0);
    check("rst_mis",   32'(if1.mismatch_cnt), 32'd0);
    check("rst_pass",  32'(if1.pass), 32'd0);
    rst = 1'b0;

    // 1: correct block
    mode = 0;
    run_scan(1, lat);
    check("t1_lat",   32'(lat), 32'd16);
    check("t1_busy_at_done", 32'(if1.busy), 32'd0);
    check("t1_table", 32'(if1.table_out), 32'hF031);
    check("t1_mis",   32'(if1.mismatch_cnt), 32'd0);
    check("t1_fv",    32'(if1.fail_valid), 32'd0);
    check("t1_pass",  32'(if1.pass), 32'd1);
    @(posedge clk); #1;
    check("t1_vec0",  32'(if1.vec), 32'd0);
    check("t1_done_pulse", 32'(if1.done), 32'd0);
    check("t1_hold_pass", 32'(if1.pass), 32'd1);

    // 2: stuck at 0
    mode = 1;
    run_scan(1, lat);
    check("t2_table", 32'(if1.table_out), 32'h0000);
    check("t2_mis",   32'(if1.mismatch_cnt), 32'd7);
    check("t2_ff",    32'(if1.first_fail), 32'd0);
    check("t2_fv",    32'(if1.fail_valid), 32'd1);
    check("t2_pass",  32'(if1.pass), 32'd0);

    // 3: single fault on vector 9, then fully inverted
    mode = 2;
    run_scan(1, lat);
    check("t3_table", 32'(if1.table_out), 32'hF231);
    check("t3_mis",   32'(if1.mismatch_cnt), 32'd1);
    check("t3_ff",    32'(if1.first_fail), 32'd9);
    check("t3_pass",  32'(if1.pass), 32'd0);
    mode = 3;
    run_scan(1, lat);
    check("t3_inv_table", 32'(if1.table_out), 32'h0FCE);
    check("t3_inv_mis",   32'(if1.mismatch_cnt), 32'd16);
    check("t3_inv_ff",    32'(if1.first_fail), 32'd0);

    // 4: slow block, SETTLE=3 passes, SETTLE=1 fails
    mode = 4;
    run_scan(3, lat);
    check("t4_lat3",   32'(lat), 32'd48);
    check("t4_pass3",  32'(if3.pass), 32'd1);
    check("t4_table3", 32'(if3.table_out), 32'hF031);
    run_scan(1, lat);
    check("t4_pass1", 32'(if1.pass), 32'd0);
    check("t4_fv1",   32'(if1.fail_valid), 32'd1);
    check("t4_ff1",   32'(if1.first_fail), 32'd1);

    // 5: reset mid-scan at vec=5
    mode = 0;
    @(posedge clk); #1;
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    lat = 0;
    while (if1.vec != 4'd5 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t5_reach_vec5", 32'(if1.vec), 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_vec",   32'(if1.vec), 32'd0);
    check("t5_busy",  32'(if1.busy), 32'd0);
    check("t5_table", 32'(if1.table_out), 32'd0);
    check("t5_ff",    32'(if1.first_fail), 32'd0);
    check("t5_fv",    32'(if1.fail_valid), 32'd0);
    @(posedge clk); #1;
    check("t5_idle",  32'(if1.busy), 32'd0);
    run_scan(1, lat);
    check("t5_lat",   32'(lat), 32'd16);
    check("t5_pass",  32'(if1.pass), 32'd1);
    check("t5_table2", 32'(if1.table_out), 32'hF031);

    // 6: start held through scan and DONE
    @(posedge clk); #1;
    if1.start = 1'b1;
    dones = 0;
    lat = 0;
    while (dones == 0 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (if1.done) dones++;
    end
    check("t6_lat", 32'(lat), 32'd17);
    @(posedge clk); #1;
    if1.start = 1'b0;
    check("t6_no_restart", 32'(if1.busy), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      if (if1.done) dones++;
    end
    check("t6_one_done", 32'(dones), 32'd1);
    check("t6_busy_idle", 32'(if1.busy), 32'd0);
    check("t6_old_pass", 32'(if1.pass), 32'd1);
    mode = 1;
    @(posedge clk); #1;
    if1.start = 1'b1;
    @(posedge clk); #1;
    if1.start = 1'b0;
    check("t6_new_busy", 32'(if1.busy), 32'd1);
    check("t6_pass_clr", 32'(if1.pass), 32'd0);
    lat = 0;
    while (!if1.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t6_new_mis", 32'(if1.mismatch_cnt), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus-and-capture stage that sits directly upstream and downstream of a combinational Boolean-function block built from a multiplexer.
- On `start`, it sweeps every input vector of an N_IN-input function onto `vec`, waits SETTLE cycles per vector, and samples the function output `f_in`.
- It assembles the full truth table and compares it against an expected table.
- It reports pass/fail, mismatch count and the first failing vector; it serves as the self-checking harness stage for the team's mux-based function blocks.

Parameters:
- N_IN, 4, number of function inputs; legal 1..6; vec[N_IN-1] drives input A (MSB).
- SETTLE, 1, cycles each vector is held before f_in is sampled; legal 1..15.
- EXPECTED, 16'hF031, expected truth table, width 2**N_IN; bit i = expected F for vec == i.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a scan; honoured only in IDLE.
- f_in  input  1  function output from the block under scan.
- vec  output  N_IN  current input vector ({A,B,C,D} for N_IN=4).
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when the scan completes.
- table_out  output  2**N_IN  captured truth table; bit i = f_in sampled for vector i.
- mismatch_cnt  output  N_IN+1  number of bits where table_out differs from EXPECTED.
- first_fail  output  N_IN  lowest failing vector index; 0 if none.
- fail_valid  output  1  high when mismatch_cnt != 0.
- pass  output  1  high when the scan completed with zero mismatches.

Behaviour:
- Reset, sampled at a clk edge, takes priority over everything, including mid-scan. After reset:
  - state = IDLE.
  - vec, busy, done, table_out, mismatch_cnt, first_fail, fail_valid and pass are all 0.
  - The settle counter and vector index are 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge E0: go to SCAN.
  - Clear table_out, mismatch_cnt, first_fail, fail_valid and pass.
  - vec=0, busy=1, settle counter = SETTLE.
  - start=0: hold all outputs; results of the previous scan remain visible.
- SCAN:
  - The counter decrements each edge.
  - At the edge where it reaches 0, i.e. SETTLE edges after vec took its current value:
    - Capture table_out[vec] <= f_in.
    - If f_in != EXPECTED[vec], increment mismatch_cnt.
    - On the first such mismatch only, set first_fail <= vec and fail_valid <= 1.
  - At the same edge:
    - If vec != 2**N_IN-1: vec <= vec+1 and counter reloads SETTLE.
    - Else: go to DONE; vec holds its last value; busy <= 0; done <= 1.
  - pass is set in the same edge: pass <= (final mismatch count == 0), with the last-vector compare included.
  - f_in is ignored on all non-sample edges; glitches within the settle window have no effect.
- DONE:
  - Lasts exactly one cycle; done=1.
  - Next edge: IDLE, done=0, vec <= 0.
  - start asserted during the DONE cycle is ignored.
- start while busy=1: ignored; the scan is not restarted.
- Scan latency:
  - done is high in the cycle following edge E0 + 2**N_IN*SETTLE.
  - Equivalently, done is high 2**N_IN*SETTLE cycles after busy rises.
- Counter widths:
  - mismatch_cnt reaches at most 2**N_IN and does not wrap.
  - The vector index stops at the terminal value and does not wrap.
- Outputs table_out, mismatch_cnt, first_fail, fail_valid and pass:
  - Are registered and stable from done until the next accepted start.
  - During a scan they update incrementally; only pass is guaranteed 0 while busy.
- All outputs are registered; no combinational path from f_in or start to any output.

Test Plan:
1. N_IN=4, SETTLE=1, f_in = EXPECTED[vec] combinationally, pulse start -> done 16 cycles after busy rises; table_out=16'hF031, mismatch_cnt=0, fail_valid=0, pass=1, vec back to 0 after DONE.
2. f_in tied to 0 -> table_out=16'h0000, mismatch_cnt=7, first_fail=0, fail_valid=1, pass=0.
3. f_in = EXPECTED[vec] except vector 9 forced to 1 -> table_out=16'hF231, mismatch_cnt=1, first_fail=9, pass=0. Then f_in = ~EXPECTED[vec] -> mismatch_cnt=16, first_fail=0.
4. SETTLE=3, f_in = EXPECTED[vec] delayed 2 cycles -> pass=1, done 48 cycles after busy rises. Same stimulus with SETTLE=1 -> pass=0, fail_valid=1.
5. Reset asserted while vec=5 -> next cycle all outputs 0, state IDLE. Then start again with a correct model -> pass=1, table_out=16'hF031.
6. start held high for the entire scan and through DONE -> exactly one scan and one done pulse. A new scan begins only on a start seen in IDLE; it clears the old pass before the first sample.
